// File: rtl/glip_pkg.sv
// Shared GLIP scaler helpers: clog2 and counter-width derivation, also used by the upscaler.
package glip_pkg;

   localparam int unsigned DEF_OUT_SIZE = 16;
   localparam int unsigned DEF_RATIO    = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p * 2) r++;
      return r;
   endfunction

   // Counter must hold 0..ratio inclusive.
   function automatic int unsigned cnt_width(input int unsigned ratio);
      return clog2(ratio + 1);
   endfunction

endpackage

// File: rtl/glip_part_shift.sv
// Word register with MSB-first part shifter; load has priority over shift.
module glip_part_shift #(
   parameter int unsigned PART_W = 16,
   parameter int unsigned PARTS  = 4
)(
   input  logic                      clk,
   input  logic                      load,
   input  logic                      shift,
   input  logic [PART_W*PARTS-1:0]   in_data,
   output logic [PART_W-1:0]         out_part
);

   localparam int unsigned W = PART_W * PARTS;

   logic [W-1:0] word;

   always_ff @(posedge clk) begin
      if (load)
         word <= in_data;
      else if (shift)
         word <= {word[W-PART_W-1:0], PART_W'(0)};
   end

   assign out_part = word[W-1 -: PART_W];

endmodule

// File: rtl/glip_downscale_n.sv
// FIFO-interface downscaler: splits RATIO*OUT_SIZE words into RATIO parts, MSB first.
// Optional GLIP_DOWNSCALE_PARTIAL_EN adds in_count for words with fewer valid parts.
module glip_downscale_n
   import glip_pkg::*;
#(
   parameter  int unsigned OUT_SIZE = DEF_OUT_SIZE,
   parameter  int unsigned RATIO    = DEF_RATIO,
   localparam int unsigned CNT_W    = cnt_width(RATIO)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [OUT_SIZE*RATIO-1:0] in_data,
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
   input  logic [CNT_W-1:0]          in_count,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [OUT_SIZE-1:0]       out_data,
   output logic                      out_valid,
   output logic                      out_last,
   input  logic                      out_ready
);

   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] load_cnt;
   logic             busy;
   logic             accept;
   logic             xfer;

   assign busy      = remain != '0;
   assign out_valid = busy;
   assign out_last  = remain == CNT_W'(1);
   assign in_ready  = !rst && (!busy || (out_ready && out_last));
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      load_cnt = CNT_W'(RATIO);
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
      if (in_count != '0 && in_count <= CNT_W'(RATIO))
         load_cnt = in_count;
`endif
   end

   // A load in the same cycle as the last part's transfer wins over the decrement.
   always_ff @(posedge clk) begin
      if (rst)
         remain <= '0;
      else if (accept)
         remain <= load_cnt;
      else if (xfer)
         remain <= remain - CNT_W'(1);
   end

   glip_part_shift #(
      .PART_W (OUT_SIZE),
      .PARTS  (RATIO)
   ) u_part_shift (
      .clk      (clk),
      .load     (accept),
      .shift    (xfer && !accept),
      .in_data  (in_data),
      .out_part (out_data)
   );

endmodule

// File: tb/tb_glip_downscale_n.sv
// Randomized bench for glip_downscale_n against a queue-of-parts reference model.
module tb_glip_downscale_n;

   localparam int unsigned OS = 8;
   localparam int unsigned RT = 4;
   localparam int unsigned CW = 3;
   localparam int unsigned W  = OS * RT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OS-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready = 1'b0;
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
   logic [CW-1:0] in_count = '0;
   logic [1:0]    in_count2 = '0;
`endif

   logic [31:0]   in_data2 = '0;
   logic          in_valid2 = 1'b0;
   logic          in_ready2;
   logic [15:0]   out_data2;
   logic          out_valid2;
   logic          out_last2;
   logic          out_ready2 = 1'b1;

   always #5 clk = ~clk;

   glip_downscale_n #(.OUT_SIZE(OS), .RATIO(RT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
      .in_count  (in_count),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   glip_downscale_n #(.OUT_SIZE(16), .RATIO(2)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data2),
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
      .in_count  (in_count2),
`endif
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .out_data  (out_data2),
      .out_valid (out_valid2),
      .out_last  (out_last2),
      .out_ready (out_ready2)
   );

   typedef struct { logic [OS-1:0] data; bit last; } part_t;
   typedef struct { logic [W-1:0] data; logic [CW-1:0] cnt; } word_t;

   part_t exp_q[$];
   word_t pend[$];
   int    errors = 0;
   int    checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned parts_of(input logic [CW-1:0] c);
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
      return (c == 0 || c > RT) ? RT : int'(c);
`else
      return (c == c) ? RT : RT;
`endif
   endfunction

   task automatic push_word(input word_t w);
      int unsigned n;
      n = parts_of(w.cnt);
      for (int unsigned i = 0; i < n; i++)
         exp_q.push_back('{data: w.data[W-1-i*OS -: OS], last: (i == n - 1)});
   endtask

   task automatic add_word(input logic [W-1:0] d, input logic [CW-1:0] c);
      pend.push_back('{data: d, cnt: c});
   endtask

   // One clock: drive at posedge+1, check and advance the model at negedge.
   task automatic cycle(input bit r, input bit offer, input bit ordy);
      bit e_valid, e_ready;
      word_t w;
      rst       = r;
      out_ready = ordy;
      in_valid  = offer && pend.size() != 0;
      if (in_valid) begin
         in_data = pend[0].data;
`ifdef GLIP_DOWNSCALE_PARTIAL_EN
         in_count = pend[0].cnt;
`endif
      end else begin
         in_data = $urandom;
      end
      @(negedge clk);
      e_valid = exp_q.size() != 0;
      e_ready = !r && (exp_q.size() == 0 || (ordy && exp_q.size() == 1));
      check("out_valid", out_valid, e_valid);
      check("in_ready", in_ready, e_ready);
      if (e_valid) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_last", out_last, exp_q[0].last);
      end else begin
         check("out_last_idle", out_last, 0);
      end
      if (r) begin
         exp_q.delete();
      end else begin
         if (e_valid && ordy) void'(exp_q.pop_front());
         if (in_valid && e_ready) begin
            w = pend.pop_front();
            push_word(w);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit stall_pat [12] = '{1,0,0,1,1,0,1,0,0,1,1,1};
      int unsigned budget;

      cycle(1, 0, 1);
      cycle(1, 0, 1);

      add_word(32'hAABBCCDD, 0);
      repeat (6) cycle(0, 1, 1);

      add_word(32'h11223344, 0);
      add_word(32'h55667788, 0);
      repeat (10) cycle(0, 1, 1);

      add_word(32'hAABBCCDD, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, stall_pat[i]);

`ifdef GLIP_DOWNSCALE_PARTIAL_EN
      add_word(32'hAABBCCDD, 2);
      add_word(32'h01020304, 0);
      add_word(32'hCAFEF00D, 7);
      repeat (12) cycle(0, 1, 1);
`endif

      add_word(32'hAABBCCDD, 0);
      repeat (3) cycle(0, 1, 1);
      cycle(1, 0, 1);
      add_word(32'h01020304, 0);
      repeat (6) cycle(0, 1, 1);

      for (int i = 0; i < 400; i++) begin
         if (pend.size() < 2)
            add_word($urandom, 3'($urandom_range(0, 7)));
         cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0);
      end

      budget = 0;
      while ((pend.size() != 0 || exp_q.size() != 0) && budget < 60) begin
         cycle(0, 1, 1);
         budget++;
      end
      check("drain", pend.size() + exp_q.size(), 0);

      in_data2  = 32'h12345678;
      in_valid2 = 1'b1;
      @(negedge clk);
      check("r2_in_ready", in_ready2, 1);
      check("r2_idle", out_valid2, 0);
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      @(negedge clk);
      check("r2_valid0", out_valid2, 1);
      check("r2_data0", out_data2, 16'h1234);
      check("r2_last0", out_last2, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("r2_valid1", out_valid2, 1);
      check("r2_data1", out_data2, 16'h5678);
      check("r2_last1", out_last2, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("r2_done", out_valid2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/glip_downscale_n.md
# glip_downscale_n

Generalised FIFO-interface downscaler. It splits each input word of RATIO×OUT_SIZE bits into RATIO output parts of OUT_SIZE bits, most-significant part first. Output is registered and `out_last` marks the final part of each word, so the block sustains one part per cycle with no bubble between words. It sits between wide on-chip GLIP/debug streams and narrow link-side interfaces (UART, USB FIFO, JTAG).

## Interface
Parameters:
- OUT_SIZE, 16, output part width in bits (≥1)
- RATIO, 4, parts per input word (≥2); input width is OUT_SIZE*RATIO
- CNT_W, $clog2(RATIO+1), width of the part counter and of `in_count` (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  OUT_SIZE*RATIO  input word; part 0 = MSB slice
- in_count  in  CNT_W  number of valid parts, MSB-aligned, 1..RATIO; 0 treated as RATIO (present only with GLIP_DOWNSCALE_PARTIAL_EN)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- out_data  out  OUT_SIZE  current part
- out_valid  out  1  part valid
- out_last  out  1  current part is the last of its word
- out_ready  in  1  part consumed when out_valid & out_ready

## Operation
- State: `word` register (RATIO×OUT_SIZE), `remain` counter (CNT_W), `busy` = remain≠0.
- `out_data` = MSB slice of `word`; `out_valid` = busy; `out_last` = (remain==1).
- Accept condition: in_ready = !rst & (!busy | (out_valid & out_ready & out_last)).
- On accept: word ← in_data; remain ← RATIO (or the effective in_count with PARTIAL_EN).
- On an output transfer without accept: word shifts left by OUT_SIZE; remain decrements.
- Accept takes priority over the decrement when both occur (last part leaves, new word loads in the same cycle).
- out_ready low: word, remain and outputs hold stable; out_valid never drops while busy (AXI-style rule).
- in_valid low with the buffer empty: out_valid=0, out_data don't-care (holds its last value).

## Timing
- Reset: remain=0, so out_valid=0, out_last=0; in_ready=0 while rst is high and 1 in the first cycle after. `word` is not reset.
- Latency: a word accepted in cycle t presents part 0 in cycle t+1.
- Throughput: RATIO parts in RATIO cycles with out_ready held high. The next word is accepted in the same cycle as the previous word's last part, so there are zero idle cycles.
- No combinational path in→out: `out_*` depends only on registers. in_ready depends combinationally on out_ready (single AND).
- Reset mid-word: remaining parts are discarded and out_valid=0 in the next cycle.

## Configuration
- GLIP_DOWNSCALE_PARTIAL_EN defined: the `in_count` port exists. The word emits min(in_count, RATIO) parts, with 0 meaning RATIO; `out_last` marks the final emitted part. Unused LSB parts are never emitted.
- Undefined: no `in_count` port; every word emits exactly RATIO parts.

## Structure
- The shared package glip_pkg holds the clog2 helper and the CNT_W derivation, reused by the matching upscaler.
- One natural sub-module: glip_part_shift (word register plus shifter, load/shift enables). Counter and handshake stay in the top.

## Test plan
- OUT_SIZE=8, RATIO=4, in_data=0xAABBCCDD, out_ready=1 → AA,BB,CC,DD on cycles t+1..t+4, out_last only on DD, in_ready=1 at t+4.
- Two back-to-back words 0x11223344 and 0x55667788 with in_valid held → 8 consecutive valid parts, no gap, out_last on 44 and 88.
- out_ready toggled 1,0,0,1,… during 0xAABBCCDD → each part held stable while stalled; order is preserved; in_ready=0 until DD transfers.
- PARTIAL_EN, in_count=2, in_data=0xAABBCCDD → AA, then BB with out_last; next word accepted with the BB transfer. in_count=0 → 4 parts.
- rst asserted after BB is emitted → next cycle out_valid=0; after reset 0x01020304 → 01,02,03,04.
- RATIO=2, OUT_SIZE=16, 0x12345678 → 1234, then 5678 with out_last; per-part throughput matches the legacy 2:1 scaler.
